// File: rtl/fetch_if.sv
// Fetch-stage bus: PC feedback from the address generator, instruction-memory
// request/response, and the IF/ID valid/ready register towards decode.
interface fetch_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic [XLEN-1:0] nxt_pc_address;
    logic            flush;
    logic [XLEN-1:0] pc_out;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            imem_rvalid;
    logic [XLEN-1:0] if_id_pc;
    logic [ILEN-1:0] if_id_instr;
    logic            if_id_valid;
    logic            id_ready;

    modport master (
        input  nxt_pc_address, flush, imem_rdata, imem_rvalid, id_ready,
        output pc_out, imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid
    );

    modport slave (
        output nxt_pc_address, flush, imem_rdata, imem_rvalid, id_ready,
        input  pc_out, imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// PC register and instruction-fetch stage: one outstanding imem request,
// a one-entry skid buffer for decode back-pressure, and branch-flush squashing.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] redir_q,     redir_d;
    logic [XLEN-1:0] if_pc_q,     if_pc_d;
    logic [ILEN-1:0] if_instr_q,  if_instr_d;
    logic            if_valid_q,  if_valid_d;
    logic [XLEN-1:0] buf_pc_q,    buf_pc_d;
    logic [ILEN-1:0] buf_instr_q, buf_instr_d;
    logic            req_q,       req_d;
    logic            slot_free;

    assign slot_free = !if_valid_q || bus.id_ready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            redir_q     <= '0;
            if_pc_q     <= '0;
            if_instr_q  <= NOP_INSTR;
            if_valid_q  <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_q     <= redir_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            req_q       <= req_d;
        end
    end

    // Next-state, PC update and IF/ID register load
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        req_d       = 1'b0;

        // A transferred entry leaves the register unless something reloads it below
        if (if_valid_q && bus.id_ready) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        if (bus.flush) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            case (state_q)
                IDLE, HOLD: begin
                    pc_d    = bus.nxt_pc_address;
                    state_d = REQ;
                end
                REQ: begin
                    if (bus.imem_rvalid) begin
                        pc_d = bus.nxt_pc_address;
                    end else begin
                        // Request still in flight: keep imem_addr stable, drain it in DROP
                        redir_d = bus.nxt_pc_address;
                        state_d = DROP;
                    end
                end
                DROP: begin
                    redir_d = bus.nxt_pc_address;
                    if (bus.imem_rvalid) begin
                        pc_d    = bus.nxt_pc_address;
                        state_d = REQ;
                    end
                end
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (bus.imem_rvalid) begin
                        if (slot_free) begin
                            if_pc_d    = pc_q;
                            if_instr_d = bus.imem_rdata;
                            if_valid_d = 1'b1;
                            pc_d       = bus.nxt_pc_address;
                        end else begin
                            buf_pc_d    = pc_q;
                            buf_instr_d = bus.imem_rdata;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // pc_q still names the buffered instruction, so nxt_pc_address follows it
                    if (bus.id_ready) begin
                        if_pc_d    = buf_pc_q;
                        if_instr_d = buf_instr_q;
                        if_valid_d = 1'b1;
                        pc_d       = bus.nxt_pc_address;
                        state_d    = REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        pc_d    = redir_q;
                        state_d = REQ;
                    end
                end
            endcase
        end

        req_d = (state_d == REQ) || (state_d == DROP);
    end

    assign bus.pc_out      = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.if_id_pc    = if_pc_q;
    assign bus.if_id_instr = if_instr_q;
    assign bus.if_id_valid = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios followed by a randomized run checked against an
// instruction-stream model (program order, memory contents, redirects).
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_if bus();

    fetch_stage #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; the address generator returns pc_out+4 unless redirecting
    task automatic cyc(input logic f, input logic [63:0] tgt, input logic rv, input logic rdy);
        bus.flush          = f;
        bus.nxt_pc_address = f ? tgt : bus.pc_out + 64'd4;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? mem(bus.imem_addr) : 32'h0;
        bus.id_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input string tag, input logic v, input logic [63:0] pc);
        chk({tag, "_valid"}, 64'(bus.if_id_valid), 64'(v));
        if (v) begin
            chk({tag, "_pc"}, bus.if_id_pc, pc);
            chk({tag, "_instr"}, 64'(bus.if_id_instr), 64'(mem(pc)));
        end else begin
            chk({tag, "_nop"}, 64'(bus.if_id_instr), 64'(NOP));
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [63:0] a);
        chk({tag, "_req"}, 64'(bus.imem_req), 64'(r));
        chk({tag, "_addr"}, bus.imem_addr, a);
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] tgt;
        logic        f, rv, rdy, xfer;
        logic        p_valid, p_req;
        logic [63:0] p_pc, p_addr;
        logic [31:0] p_instr;
        int          idle_cnt;
        int          n_xfer;

        bus.flush = 1'b0; bus.nxt_pc_address = '0; bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0; bus.id_ready = 1'b0;

        // 1: reset, then one idle cycle before the first request at RESET_PC
        rst = 1'b1;
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        chk_req("rst", 1'b0, 64'h0);
        chk("rst_pc", bus.pc_out, 64'h0);
        chk_entry("rst", 1'b0, '0);
        chk("rst_if_pc", bus.if_id_pc, 64'h0);
        rst = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk_req("first", 1'b1, 64'h0);

        // 2: same-cycle responses stream one instruction per cycle
        cyc(1'b0, '0, 1'b1, 1'b1);  chk_entry("s0", 1'b1, 64'h0);  chk_req("s0", 1'b1, 64'h4);
        cyc(1'b0, '0, 1'b1, 1'b1);  chk_entry("s4", 1'b1, 64'h4);  chk_req("s4", 1'b1, 64'h8);
        cyc(1'b0, '0, 1'b1, 1'b1);  chk_entry("s8", 1'b1, 64'h8);  chk_req("s8", 1'b1, 64'hC);

        // 3: decode stall while a response arrives parks it; release resumes fetch
        cyc(1'b0, '0, 1'b1, 1'b0);  chk_entry("hold", 1'b1, 64'h8); chk_req("hold", 1'b0, 64'hC);
        cyc(1'b0, '0, 1'b0, 1'b1);  chk_entry("unhold", 1'b1, 64'hC); chk_req("unhold", 1'b1, 64'h10);

        // 4: flush with a request pending drains it, then refetches at the target
        cyc(1'b1, 64'h100, 1'b0, 1'b1); chk_entry("drop", 1'b0, '0); chk_req("drop", 1'b1, 64'h10);
        cyc(1'b0, '0, 1'b1, 1'b1);      chk_entry("drain", 1'b0, '0); chk_req("drain", 1'b1, 64'h100);
        cyc(1'b0, '0, 1'b1, 1'b1);      chk_entry("tgt", 1'b1, 64'h100);

        // 5: flush during HOLD, then flush alongside a response (2-byte aligned target)
        cyc(1'b0, '0, 1'b1, 1'b0);      chk_req("hold2", 1'b0, 64'h104);
        cyc(1'b1, 64'h200, 1'b0, 1'b0); chk_entry("fl_hold", 1'b0, '0); chk_req("fl_hold", 1'b1, 64'h200);
        cyc(1'b1, 64'h302, 1'b1, 1'b1); chk_entry("fl_rv", 1'b0, '0); chk_req("fl_rv", 1'b1, 64'h302);
        cyc(1'b0, '0, 1'b1, 1'b1);      chk_entry("odd", 1'b1, 64'h302); chk_req("odd", 1'b1, 64'h306);

        // 6: reset while draining, stray response afterwards is ignored
        cyc(1'b1, 64'h400, 1'b0, 1'b1); chk_req("drop2", 1'b1, 64'h306);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b1);      chk_req("rst2", 1'b0, 64'h0); chk_entry("rst2", 1'b0, '0);
        rst = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b1);      chk_req("stray", 1'b1, 64'h0); chk_entry("stray", 1'b0, '0);

        // Randomized run: decoded stream must follow program order from the latest redirect
        exp_pc   = 64'h0;
        idle_cnt = 0;
        n_xfer   = 0;
        for (int i = 0; i < 3000; i++) begin
            f   = ($urandom_range(0, 99) < 5);
            tgt = {$urandom, $urandom} & ~64'h1;
            rv  = bus.imem_req && ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 70);
            p_valid = bus.if_id_valid; p_pc = bus.if_id_pc; p_instr = bus.if_id_instr;
            p_req   = bus.imem_req;    p_addr = bus.imem_addr;
            xfer = p_valid && rdy && !f;
            if (xfer) begin
                chk("rnd_pc", p_pc, exp_pc);
                chk("rnd_instr", 64'(p_instr), 64'(mem(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_xfer++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (f) exp_pc = tgt;
            cyc(f, tgt, rv, rdy);
            if (!bus.if_id_valid) chk("rnd_nop", 64'(bus.if_id_instr), 64'(NOP));
            if (p_valid && !rdy && !f) begin
                chk("rnd_stable_v", 64'(bus.if_id_valid), 64'h1);
                chk("rnd_stable_pc", bus.if_id_pc, p_pc);
                chk("rnd_stable_i", 64'(bus.if_id_instr), 64'(p_instr));
            end
            if (p_req && !rv) begin
                chk("rnd_req_hold", 64'(bus.imem_req), 64'h1);
                chk("rnd_addr_hold", bus.imem_addr, p_addr);
            end
            if (idle_cnt > 300) begin
                chk("rnd_liveness", 64'(idle_cnt), 64'h0);
                break;
            end
        end
        chk("rnd_xfer_count", 64'(n_xfer > 200), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
